binary_counter_nbit_updown: RTL



---
 rtl/binary_counter_nbit_updown.sv | 71 +++++++
 1 files changed

// File: rtl/binary_counter_nbit_updown.sv
// Parametrised synchronous up/down modulo counter with parallel load, enable,
// terminal-count and wrap flags. Define BINARY_COUNTER_NBIT_SATURATE_EN to saturate instead of wrap.
module binary_counter_nbit_updown #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_VALUE = (2 ** WIDTH) - 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_bar,
  output logic             terminal_count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_C  = MAX_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ZERO_C = '0;
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             at_max, at_zero;
  logic [WIDTH-1:0] load_clamped;

  assign at_max         = (count_q == MAX_C);
  assign at_zero        = (count_q == ZERO_C);
  assign terminal_count = (up_down & at_max) | (~up_down & at_zero);
  assign load_clamped   = (load_value > MAX_C) ? MAX_C : load_value;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_clamped;
    end else if (enable) begin
      // In saturating builds the same flag marks an attempted step past the end.
      wrap_d = terminal_count;
      if (up_down) begin
`ifdef BINARY_COUNTER_NBIT_SATURATE_EN
        count_d = at_max ? MAX_C : (count_q + ONE_C);
`else
        count_d = at_max ? ZERO_C : (count_q + ONE_C);
`endif
      end else begin
`ifdef BINARY_COUNTER_NBIT_SATURATE_EN
        count_d = at_zero ? ZERO_C : (count_q - ONE_C);
`else
        count_d = at_zero ? MAX_C : (count_q - ONE_C);
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= ZERO_C;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count     = count_q;
  assign count_bar = ~count_q;
  assign wrap      = wrap_q;

endmodule
